// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited word requests and buffers {pc, instr} for decode.
// Optional misaligned-redirect fault checking is enabled with FETCH_MISALIGN_CHK_EN.
module fetch_unit #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2,
  parameter int              CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic            fetch_fault
);

  localparam int               PTR_W  = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W:0]   CREDIT = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(FIFO_DEPTH);

  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  fifo_instr [FIFO_DEPTH];
  logic [XLEN-1:0]  fifo_pc    [FIFO_DEPTH];
  logic [XLEN-1:0]  pcq        [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, pcq_wr, pcq_rd;
  logic [CNT_W-1:0] count, inflight, drop;
  logic [CNT_W:0]   occupancy;
  logic [XLEN-1:0]  redirect_target;
  logic             credit_ok, req_fire, rsp_fire, dropping, push, pop;

  // Handshakes: a transfer happens in a cycle where valid & ready are both high at the rising edge;
  // valid never depends on ready. Responses have no ready and are always consumed.
  assign occupancy = {1'b0, inflight} + {1'b0, count};
  assign credit_ok = occupancy < CREDIT;
  assign req_fire  = imem_req_valid & imem_req_ready;
  assign rsp_fire  = imem_rsp_valid;
  assign dropping  = drop != '0;
  assign push      = rsp_fire & ~dropping & ~redirect_valid;
  assign pop       = if_valid & if_ready & ~redirect_valid;

  assign imem_req_addr = pc_q;
  assign if_valid      = count != '0;
  assign if_instr      = if_valid ? fifo_instr[rd_ptr] : '0;
  assign if_pc         = if_valid ? fifo_pc[rd_ptr] : '0;

`ifdef FETCH_MISALIGN_CHK_EN
  logic fault_halt;

  assign redirect_target = redirect_pc;
  assign imem_req_valid  = rst_n & credit_ok & ~redirect_valid & ~fault_halt;
  assign fetch_fault     = fault_halt;

  // A misaligned target parks fetch until a later redirect lands on a word boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_halt <= 1'b0;
    end else if (redirect_valid) begin
      fault_halt <= |redirect_pc[1:0];
    end
  end
`else
  logic unused_lsbs;

  assign unused_lsbs     = ^redirect_pc[1:0];
  assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};
  assign imem_req_valid  = rst_n & credit_ok & ~redirect_valid;
  assign fetch_fault     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (redirect_valid) begin
      pc_q <= redirect_target;
    end else if (req_fire) begin
      pc_q <= pc_q + XLEN'(4);
    end
  end

  // Every outstanding word, including ones already marked stale, becomes stale exactly once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
      drop     <= '0;
    end else begin
      case ({req_fire, rsp_fire})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
      if (redirect_valid) begin
        drop <= (rsp_fire && inflight != '0) ? inflight - CNT_W'(1)
              : (rsp_fire ? '0 : inflight);
      end else if (rsp_fire && dropping) begin
        drop <= drop - CNT_W'(1);
      end
    end
  end

  // PC side-queue only holds addresses of non-stale requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcq_wr <= '0;
      pcq_rd <= '0;
    end else if (redirect_valid) begin
      pcq_wr <= '0;
      pcq_rd <= '0;
    end else begin
      if (req_fire) pcq_wr <= pcq_wr + PTR_W'(1);
      if (rsp_fire && !dropping) pcq_rd <= pcq_rd + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) pcq[pcq_wr] <= pc_q;
    if (push) begin
      fifo_instr[wr_ptr] <= imem_rsp_data;
      fifo_pc[wr_ptr]    <= pcq[pcq_rd];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && count == FULL_C));
  a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rsp_valid && inflight == '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: an epoch-tagged memory/decode model predicts requests and delivered {pc, instr}.
module tb_fetch_unit;

  localparam int FIFO_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        fetch_fault;

  fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .fetch_fault(fetch_fault)
  );

  // Clock and reset
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } mreq_t;

  mreq_t       memq[$];
  logic [63:0] exp_q[$];
  logic [31:0] pc_m;
  bit          fault_m;
  int          epoch, cyc;
  int          p_rdy, p_mrdy, lat_lo, lat_hi;
  int          n_checks = 0;
  int          n_errors = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_clear();
    memq.delete();
    exp_q.delete();
    pc_m    = 32'h0000_0000;
    fault_m = 1'b0;
    epoch++;
    cyc     = 0;
  endtask

  task automatic drive_idle();
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if_ready       = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_pc", if_pc, 32'd0);
    check("rst_if_instr", if_instr, 32'd0);
    check("rst_fetch_fault", 32'(fetch_fault), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    drive_idle();
    #1 check_reset_outputs();
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One clock cycle: drive inputs, compare outputs against the model, then advance the model.
  task automatic step(input bit redir, input logic [31:0] tgt);
    bit          exp_req, rsp;
    mreq_t       e;
    logic [63:0] hd;
    int          due;
    @(negedge clk);
    rsp            = (memq.size() > 0) && (memq[0].due <= cyc);
    redirect_valid = redir;
    redirect_pc    = tgt;
    if_ready       = ($urandom_range(0, 99) < p_rdy);
    imem_req_ready = ($urandom_range(0, 99) < p_mrdy);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(memq[0].addr) : 32'h0;
    #1;
    exp_req = (memq.size() + exp_q.size() < FIFO_DEPTH) && !redir && !fault_m;
    check("req_valid", 32'(imem_req_valid), 32'(exp_req));
    if (exp_req) check("req_addr", imem_req_addr, pc_m);
    check("if_valid", 32'(if_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      hd = exp_q[0];
      check("if_pc", if_pc, hd[63:32]);
      check("if_instr", if_instr, hd[31:0]);
    end else begin
      check("if_pc_empty", if_pc, 32'd0);
      check("if_instr_empty", if_instr, 32'd0);
    end
    check("fetch_fault", 32'(fetch_fault), 32'(fault_m));

    if (exp_q.size() > 0 && if_ready && !redir) void'(exp_q.pop_front());
    if (rsp) begin
      e = memq.pop_front();
      if (e.epoch == epoch && !redir) exp_q.push_back({e.addr, mem_word(e.addr)});
    end
    if (redir) begin
      exp_q.delete();
      epoch++;
`ifdef FETCH_MISALIGN_CHK_EN
      pc_m    = tgt;
      fault_m = (tgt[1:0] != 2'b00);
`else
      pc_m    = {tgt[31:2], 2'b00};
`endif
    end else if (exp_req && imem_req_ready) begin
      due = cyc + $urandom_range(lat_lo, lat_hi);
      if (memq.size() > 0 && memq[$].due >= due) due = memq[$].due + 1;
      memq.push_back('{pc_m, due, epoch});
      pc_m = pc_m + 32'd4;
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0);
  endtask

  task automatic knobs(input int rdy, input int mrdy, input int lo, input int hi);
    p_rdy = rdy; p_mrdy = mrdy; lat_lo = lo; lat_hi = hi;
  endtask

  initial begin
    logic [31:0] tgt;
    bit          redir;
    epoch = 0;
    rst_n = 1'b0;
    drive_idle();
    #3 check_reset_outputs();
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Free-running memory with latency 1, decode always ready
    knobs(100, 100, 1, 1);
    run(20);
    // Decode stalls: FIFO fills and requests stop, then drain in order
    knobs(0, 100, 1, 1);
    run(10);
    knobs(100, 100, 1, 1);
    run(10);
    // Latency-3 memory with stale words in flight at the redirect
    knobs(100, 100, 3, 3);
    run(6);
    step(1'b1, 32'h0000_0100);
    run(12);
    // Steady stream: redirect coincides with a response and a decode handshake
    knobs(100, 100, 1, 1);
    run(8);
    step(1'b1, 32'h0000_0040);
    run(8);
    // PC wrap-around
    step(1'b1, 32'hFFFF_FFF8);
    run(8);
    // Reset in the middle of a latency-3 stream
    knobs(100, 100, 3, 3);
    run(7);
    do_reset();
    run(10);
    // Misaligned redirect, then an aligned one
    knobs(100, 100, 1, 2);
    run(4);
    step(1'b1, 32'h0000_0102);
    run(6);
    step(1'b1, 32'h0000_0200);
    run(10);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0)
        knobs($urandom_range(0, 100), $urandom_range(20, 100), 1, $urandom_range(1, 4));
      redir = ($urandom_range(0, 99) < 5);
      tgt   = $urandom & 32'h0000_0FFC;
      if ($urandom_range(0, 9) == 0) tgt = tgt | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 19) == 0) tgt = 32'hFFFF_FFF0;
      step(redir, tgt);
      if (i == 750) do_reset();
    end
    run(10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
